// File: rtl/xilinx_pci_clk_ctrl_pkg.sv
// Shared state encoding and sizing helper for the PCIe PIPE clock sequencer.
package xilinx_pci_clk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_SWITCH     = 3'd4,
    ST_ACK        = 3'd5,
    ST_FAIL       = 3'd6
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/xilinx_pci_clk_ctrl_sync.sv
// Two-flop synchroniser for the asynchronous MMCM LOCKED input.
module xilinx_pci_clk_ctrl_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic r_ff1;
  (* ASYNC_REG = "TRUE" *) logic r_ff2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/xilinx_pci_clk_ctrl.sv
// PIPE clocking MMCM sequencer: reset/lock qualification, rate switching and
// bounded re-initialisation, all on the free-running control clock.
module xilinx_pci_clk_ctrl
  import xilinx_pci_clk_ctrl_pkg::*;
#(
  parameter int PCIE_LANE          = 2,
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int LOCK_WAIT_CYCLES   = 65535,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int RATE_GAP_CYCLES    = 16,
  parameter int MAX_RETRY          = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               mmcm_lock_i,
  output logic                               mmcm_rst_n_o,
  output logic                               pipeclk_en_o,
  input  logic                               rate_req_i,
  input  logic                               rate_gen2_i,
  output logic                               rate_ack_o,
  output logic [PCIE_LANE-1:0]               pclk_sel_o,
  output logic                               clk_ready_o,
  output logic                               fail_o,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt_o,
  output logic [2:0]                         state_o
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int CW = $clog2(max4(RST_HOLD_CYCLES, LOCK_WAIT_CYCLES,
                                  LOCK_STABLE_CYCLES, RATE_GAP_CYCLES) + 1);
  localparam logic [CW-1:0] C_RST  = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_WAIT = CW'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] C_STB  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(RATE_GAP_CYCLES - 1);
  localparam logic [RW-1:0] C_MAXR = RW'(MAX_RETRY);

  state_e          r_state, w_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_lock_s;
  logic            w_retry;
  logic            w_run;

  xilinx_pci_clk_ctrl_sync u_lock_sync (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_d     (mmcm_lock_i),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_nxt   = r_state;
    w_retry = 1'b0;
    case (r_state)
      ST_RESET_HOLD: if (r_cnt == C_RST) w_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_lock_s)            w_nxt   = ST_STABLE;
        else if (r_cnt == C_WAIT) w_retry = 1'b1;
      end
      ST_STABLE: begin
        // A glitch here only restarts the lock wait; it is not a retry.
        if (!w_lock_s)           w_nxt = ST_WAIT_LOCK;
        else if (r_cnt == C_STB) w_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lock_s)       w_retry = 1'b1;
        else if (rate_req_i) w_nxt   = (rate_gen2_i != pclk_sel_o[0]) ? ST_SWITCH : ST_ACK;
      end
      ST_SWITCH: begin
        if (!w_lock_s)           w_retry = 1'b1;
        else if (r_cnt == C_GAP) w_nxt   = ST_ACK;
      end
      ST_ACK: begin
        if (!w_lock_s) w_retry = 1'b1;
        else           w_nxt   = ST_RUN;
      end
      ST_FAIL: w_nxt = ST_FAIL;
      default: w_nxt = ST_RESET_HOLD;
    endcase
    if (w_retry) w_nxt = (retry_cnt_o == C_MAXR) ? ST_FAIL : ST_RESET_HOLD;
  end

  assign w_run   = (w_nxt == ST_RUN) || (w_nxt == ST_SWITCH) || (w_nxt == ST_ACK);
  assign state_o = r_state;

  // Outputs are registered from the next state so they move on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_RESET_HOLD;
      r_cnt        <= '0;
      retry_cnt_o  <= '0;
      mmcm_rst_n_o <= 1'b0;
      pipeclk_en_o <= 1'b0;
      clk_ready_o  <= 1'b0;
      rate_ack_o   <= 1'b0;
      fail_o       <= 1'b0;
      pclk_sel_o   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)  r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;

      if (w_nxt == ST_RUN && r_state != ST_RUN)    retry_cnt_o <= '0;
      else if (w_retry && w_nxt == ST_RESET_HOLD) retry_cnt_o <= retry_cnt_o + 1'b1;

      mmcm_rst_n_o <= w_run || (w_nxt == ST_WAIT_LOCK) || (w_nxt == ST_STABLE);
      pipeclk_en_o <= w_run;
      clk_ready_o  <= w_run;
      rate_ack_o   <= (w_nxt == ST_ACK);
      fail_o       <= (w_nxt == ST_FAIL);

      if (!w_run)                                      pclk_sel_o <= '0;
      else if (r_state == ST_RUN && w_nxt == ST_SWITCH) pclk_sel_o <= {PCIE_LANE{rate_gen2_i}};
    end
  end

endmodule

// File: tb/tb_xilinx_pci_clk_ctrl.sv
// Directed bench for xilinx_pci_clk_ctrl with a phase/time reference model.
module tb_xilinx_pci_clk_ctrl;

  localparam int RH = 4, LW = 20, LS = 8, RG = 6, MR = 2, NL = 2;

  logic clk = 1'b0;
  logic rst_n, lock, req, gen2;
  logic mmcm_rst_n, en, ack, ready, fail;
  logic [NL-1:0] sel;
  logic [1:0] retry;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  xilinx_pci_clk_ctrl #(
    .PCIE_LANE(NL), .RST_HOLD_CYCLES(RH), .LOCK_WAIT_CYCLES(LW),
    .LOCK_STABLE_CYCLES(LS), .RATE_GAP_CYCLES(RG), .MAX_RETRY(MR)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mmcm_lock_i(lock),
    .mmcm_rst_n_o(mmcm_rst_n), .pipeclk_en_o(en),
    .rate_req_i(req), .rate_gen2_i(gen2), .rate_ack_o(ack),
    .pclk_sel_o(sel), .clk_ready_o(ready), .fail_o(fail),
    .retry_cnt_o(retry), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase number, cycles spent in phase, retries, rate.
  int m_ph, m_t, m_ret;
  bit m_sel, h0, h1;

  task automatic m_enter(input int p);
    m_ph = p;
    m_t  = 0;
  endtask

  task automatic m_reset();
    m_enter(0); m_ret = 0; m_sel = 0; h0 = 0; h1 = 0;
  endtask

  task automatic m_retry();
    m_sel = 0;
    if (m_ret == MR) m_enter(6);
    else begin m_ret++; m_enter(0); end
  endtask

  task automatic m_step();
    bit ls;
    ls = h1; h1 = h0; h0 = lock;
    case (m_ph)
      0: begin m_t++; if (m_t >= RH) m_enter(1); end
      1: begin m_t++; if (ls) m_enter(2); else if (m_t >= LW) m_retry(); end
      2: if (!ls) m_enter(1);
         else begin m_t++; if (m_t >= LS) begin m_enter(3); m_ret = 0; end end
      3: if (!ls) m_retry();
         else if (req) begin
           if (gen2 != m_sel) begin m_sel = gen2; m_enter(4); end
           else m_enter(5);
         end
      4: if (!ls) m_retry(); else begin m_t++; if (m_t >= RG) m_enter(5); end
      5: if (!ls) m_retry(); else m_enter(3);
      default: ;
    endcase
  endtask

  function automatic logic [10:0] exp_pack();
    bit mr, rn;
    mr = (m_ph >= 1 && m_ph <= 5);
    rn = (m_ph >= 3 && m_ph <= 5);
    return {3'(m_ph), 2'(m_ret), (m_ph == 6), rn, {NL{m_sel}}, (m_ph == 5), rn, mr};
  endfunction

  function automatic logic [10:0] act_pack();
    return {state, retry, fail, ready, sel, ack, en, mmcm_rst_n};
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cycle_model", 32'(act_pack()), 32'(exp_pack()));
  end

  function automatic logic sig(input int which);
    case (which)
      0: return mmcm_rst_n;
      1: return ready;
      2: return ack;
      3: return fail;
      default: return (state == 3'(which - 10));
    endcase
  endfunction

  // Count negedges until the selected signal equals val; expiry is a failure.
  task automatic wait_for(input string nm, input int which, input logic val,
                          input int budget, output int n);
    n = 0;
    while (sig(which) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(which) !== val) chk({nm, "_timeout"}, 32'(sig(which)), 32'(val));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    chk("reset_outs", 32'(act_pack()), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, acks, r1, r2;
    rst_n = 1'b1; lock = 1'b0; req = 1'b0; gen2 = 1'b0;
    #2;

    // 1: bring-up
    do_reset();
    wait_for("rst_hold", 0, 1'b1, 50, n);
    chk("rst_hold_len", n, 4);
    tick(3);
    lock = 1'b1;
    wait_for("run1", 1, 1'b1, 100, n);
    chk("ready_after_lock", n, 11);
    chk("en_in_run", en, 1);

    // 2: switch to 250 MHz
    req = 1'b1; gen2 = 1'b1;
    @(negedge clk);
    chk("sel_gen2", sel, 2'b11);
    chk("state_switch", state, 4);
    wait_for("ack2", 2, 1'b1, 20, n);
    chk("ack_gap", n, 6);
    req = 1'b0;
    @(negedge clk);
    chk("ack_single", ack, 0);
    chk("state_run2", state, 3);

    // 3: same-rate then back to 125 MHz
    req = 1'b1; gen2 = 1'b1;
    @(negedge clk);
    chk("same_rate_ack", ack, 1);
    chk("same_rate_sel", sel, 2'b11);
    req = 1'b0;
    @(negedge clk);
    chk("same_rate_ack_drop", ack, 0);
    req = 1'b1; gen2 = 1'b0;
    @(negedge clk);
    chk("sel_gen1", sel, 2'b00);
    wait_for("ack3", 2, 1'b1, 20, n);
    chk("ack_gap_gen1", n, 6);
    req = 1'b0;
    tick(2);

    // 6: lock drop mid-switch, held request served after relock
    req = 1'b1; gen2 = 1'b1;
    @(negedge clk);
    chk("state_switch6", state, 4);
    tick(1);
    lock = 1'b0;
    acks = 0;
    repeat (3) begin @(negedge clk); acks += int'(ack); end
    chk("drop_no_ack", acks, 0);
    chk("drop_state", state, 0);
    chk("drop_en", en, 0);
    chk("drop_sel", sel, 0);
    chk("drop_retry", retry, 1);
    tick(2);
    lock = 1'b1;
    wait_for("run6", 1, 1'b1, 100, n);
    chk("relock_retry_clr", retry, 0);
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack) begin acks++; req = 1'b0; end
    end
    chk("held_req_acks", acks, 1);
    chk("held_req_sel", sel, 2'b11);

    // 5: lock glitch in STABLE
    lock = 1'b0; req = 1'b0;
    do_reset();
    wait_for("rst_hold5", 0, 1'b1, 50, n);
    lock = 1'b1;
    wait_for("stable5", 12, 1'b1, 20, n);
    tick(2);
    lock = 1'b0;
    tick(3);
    chk("glitch_state", state, 1);
    chk("glitch_retry", retry, 0);
    lock = 1'b1;
    wait_for("run5", 1, 1'b1, 100, n);
    chk("glitch_ready_delay", n, 11);

    // 4: no lock ever -> retries then FAIL
    lock = 1'b0;
    do_reset();
    n = 0; r1 = -1; r2 = -1;
    while (!fail && n < 200) begin
      @(negedge clk);
      n++;
      if (retry == 2'd1 && r1 < 0) r1 = n;
      if (retry == 2'd2 && r2 < 0) r2 = n;
    end
    chk("retry1_at", r1, 24);
    chk("retry2_at", r2, 48);
    chk("fail_at", n, 72);
    lock = 1'b1;
    tick(30);
    chk("fail_sticky", fail, 1);
    chk("fail_state", state, 6);
    chk("fail_mmcm_rst", mmcm_rst_n, 0);
    chk("fail_en", en, 0);
    chk("fail_retry", retry, 2);
    rst_n = 1'b0;
    tick(2);
    chk("fail_cleared", fail, 0);
    chk("fail_reset_state", state, 0);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
